// File: rtl/jay_pkg.sv
// jay_pkg: shared types and constants for the jay_core multi-cycle 9-bit processor.
package jay_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_XOR  = 3'd1,
    OP_SHL  = 3'd2,
    OP_ADDI = 3'd3,
    OP_LD   = 3'd4,
    OP_ST   = 3'd5,
    OP_BNZ  = 3'd6,
    OP_HALT = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Instruction field slices: opcode [8:6], rA [5:3], rB/imm3 [2:0]
  localparam int OP_HI = 8;
  localparam int OP_LO = 6;
  localparam int RA_HI = 5;
  localparam int RA_LO = 3;
  localparam int RB_HI = 2;
  localparam int RB_LO = 0;

  function automatic opcode_e get_op(input logic [8:0] insn);
    return opcode_e'(insn[OP_HI:OP_LO]);
  endfunction

  function automatic logic [2:0] get_ra(input logic [8:0] insn);
    return insn[RA_HI:RA_LO];
  endfunction

  function automatic logic [2:0] get_rb(input logic [8:0] insn);
    return insn[RB_HI:RB_LO];
  endfunction

endpackage

// File: rtl/jay_if.sv
// jay_if: start/done handshake plus instruction and data memory ports of jay_core.
interface jay_if #(
  parameter int W = 8,
  parameter int D = 12
);
  logic         start;
  logic         busy;
  logic         done;
  logic [D-1:0] imem_addr;
  logic         imem_rd;
  logic [8:0]   imem_data;
  logic [W-1:0] dmem_addr;
  logic         dmem_re;
  logic         dmem_we;
  logic [W-1:0] dmem_wdata;
  logic [W-1:0] dmem_rdata;

  // Processor side
  modport master (
    input  start,
    output busy, done,
    output imem_addr, imem_rd,
    input  imem_data,
    output dmem_addr, dmem_re, dmem_we, dmem_wdata,
    input  dmem_rdata
  );

  // Host / memory side
  modport slave (
    output start,
    input  busy, done,
    input  imem_addr, imem_rd,
    output imem_data,
    input  dmem_addr, dmem_re, dmem_we, dmem_wdata,
    output dmem_rdata
  );
endinterface

// File: rtl/jay_alu.sv
// jay_alu: combinational ALU for ADD, XOR, SHL and ADDI (ADDI's immediate arrives on b).
module jay_alu
  import jay_pkg::*;
#(
  parameter int W = 8
) (
  input  opcode_e      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sc_i,
  output logic [W-1:0] rslt,
  output logic         sc_o,
  output logic         zero
);

  logic [W:0] sum_s;

  // Result and carry/shift flag; opcodes that do not touch sc pass sc_i through
  always_comb begin
    sum_s = {1'b0, a} + {1'b0, b};
    rslt  = a;
    sc_o  = sc_i;
    case (op)
      OP_ADD, OP_ADDI: begin
        rslt = sum_s[W-1:0];
        sc_o = sum_s[W];
      end
      OP_XOR: begin
        rslt = a ^ b;
        sc_o = sc_i;
      end
      OP_SHL: begin
        rslt = {a[W-2:0], sc_i};
        sc_o = a[W-1];
      end
      default: begin
        rslt = a;
        sc_o = sc_i;
      end
    endcase
  end

  assign zero = (rslt == {W{1'b0}});

endmodule

// File: rtl/jay_core.sv
// jay_core: multi-cycle 9-bit-instruction processor (IDLE/FETCH/EXEC/MEM/DONE).
// Optional feature: define JAY_CYCLE_COUNT_EN to add the saturating 32-bit cycle_cnt port.
module jay_core
  import jay_pkg::*;
#(
  parameter int W        = 8,
  parameter int D        = 12,
  parameter int START_PC = 0,
  parameter int END_PC   = 128
) (
  input logic   clk,
  input logic   reset,
  jay_if.master bus
`ifdef JAY_CYCLE_COUNT_EN
  ,
  output logic [31:0] cycle_cnt
`endif
);

  localparam logic [D-1:0] START_PC_V = D'(START_PC);
  localparam logic [D-1:0] END_PC_V   = D'(END_PC);

  state_e       state_r, state_n;
  logic [D-1:0] pc_r, pc_n;
  logic [8:0]   ir_r, ir_n;
  logic         z_r, z_n;
  logic         sc_r, sc_n;
  logic         busy_r, busy_n;
  logic         done_r, done_n;
  logic         imem_rd_r;

  logic [W-1:0] rf_r [8];
  logic         rf_we_s;
  logic [2:0]   rf_wa_s;
  logic [W-1:0] rf_wd_s;

  logic         dmem_re_s, dmem_we_s;
  logic [W-1:0] dmem_addr_s, dmem_wdata_s;

  opcode_e      op_s;
  logic [2:0]   ra_s, rb_s;
  logic [W-1:0] alu_b_s, alu_rslt_s;
  logic         alu_sc_s, alu_zero_s;

  assign op_s    = get_op(bus.imem_data);
  assign ra_s    = get_ra(bus.imem_data);
  assign rb_s    = get_rb(bus.imem_data);
  assign alu_b_s = (op_s == OP_ADDI) ? {{(W-3){1'b0}}, rb_s} : rf_r[rb_s];

  jay_alu #(.W(W)) u_alu (
    .op   (op_s),
    .a    (rf_r[ra_s]),
    .b    (alu_b_s),
    .sc_i (sc_r),
    .rslt (alu_rslt_s),
    .sc_o (alu_sc_s),
    .zero (alu_zero_s)
  );

  // Next-state, write-back and memory-strobe decode; instruction word is only valid in EXEC
  always_comb begin
    state_n      = state_r;
    pc_n         = pc_r;
    ir_n         = ir_r;
    z_n          = z_r;
    sc_n         = sc_r;
    busy_n       = busy_r;
    done_n       = done_r;
    rf_we_s      = 1'b0;
    rf_wa_s      = 3'd0;
    rf_wd_s      = {W{1'b0}};
    dmem_re_s    = 1'b0;
    dmem_we_s    = 1'b0;
    dmem_addr_s  = {W{1'b0}};
    dmem_wdata_s = {W{1'b0}};
    case (state_r)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          pc_n    = START_PC_V;
          sc_n    = 1'b0;
          z_n     = 1'b0;
          done_n  = 1'b0;
          busy_n  = 1'b1;
          state_n = S_FETCH;
        end else begin
          state_n = state_r;
        end
      end
      S_FETCH: begin
        if (pc_r == END_PC_V) begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        ir_n = bus.imem_data;
        case (op_s)
          OP_ADD, OP_XOR, OP_SHL, OP_ADDI: begin
            rf_we_s = 1'b1;
            rf_wa_s = ra_s;
            rf_wd_s = alu_rslt_s;
            z_n     = alu_zero_s;
            sc_n    = alu_sc_s;
            pc_n    = pc_r + D'(1);
            state_n = S_FETCH;
          end
          OP_LD: begin
            dmem_re_s   = 1'b1;
            dmem_addr_s = rf_r[rb_s];
            state_n     = S_MEM;
          end
          OP_ST: begin
            dmem_we_s    = 1'b1;
            dmem_addr_s  = rf_r[rb_s];
            dmem_wdata_s = rf_r[ra_s];
            pc_n         = pc_r + D'(1);
            state_n      = S_FETCH;
          end
          OP_BNZ: begin
            if (!z_r) begin
              pc_n = D'(rf_r[rb_s]);
            end else begin
              pc_n = pc_r + D'(1);
            end
            state_n = S_FETCH;
          end
          OP_HALT: begin
            state_n = S_DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
          default: begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
          end
        endcase
      end
      S_MEM: begin
        // Load data arrives this cycle; the address is held from the EXEC cycle
        dmem_addr_s = rf_r[get_rb(ir_r)];
        if (get_op(ir_r) == OP_LD) begin
          rf_we_s = 1'b1;
          rf_wa_s = get_ra(ir_r);
          rf_wd_s = bus.dmem_rdata;
          z_n     = (bus.dmem_rdata == {W{1'b0}});
          pc_n    = pc_r + D'(1);
          state_n = S_FETCH;
        end else begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b0;
      end
    endcase
  end

  // Control and architectural state registers; imem_rd is pre-computed for the coming FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      pc_r      <= {D{1'b0}};
      ir_r      <= 9'd0;
      z_r       <= 1'b0;
      sc_r      <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      imem_rd_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      pc_r      <= pc_n;
      ir_r      <= ir_n;
      z_r       <= z_n;
      sc_r      <= sc_n;
      busy_r    <= busy_n;
      done_r    <= done_n;
      imem_rd_r <= (state_n == S_FETCH) && (pc_n != END_PC_V);
    end
  end

  // Register file write-back at the edge ending EXEC or MEM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        rf_r[i] <= {W{1'b0}};
      end
    end else if (rf_we_s) begin
      rf_r[rf_wa_s] <= rf_wd_s;
    end
  end

`ifdef JAY_CYCLE_COUNT_EN
  logic [31:0] cnt_r;

  // Run-cycle counter: cleared on accepted start, counts busy cycles, saturates, frozen otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= 32'd0;
    end else if (((state_r == S_IDLE) || (state_r == S_DONE)) && bus.start) begin
      cnt_r <= 32'd0;
    end else if (busy_r && (cnt_r != 32'hFFFF_FFFF)) begin
      cnt_r <= cnt_r + 32'd1;
    end
  end

  assign cycle_cnt = cnt_r;
`endif

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.imem_addr  = pc_r;
  assign bus.imem_rd    = imem_rd_r;
  assign bus.dmem_re    = dmem_re_s;
  assign bus.dmem_we    = dmem_we_s;
  assign bus.dmem_addr  = dmem_addr_s;
  assign bus.dmem_wdata = dmem_wdata_s;

endmodule

// File: tb/tb_jay_core.sv
// tb_jay_core: table-driven ALU vectors plus hand-written run sequences for jay_core,
// with a scoreboard of expected data-memory writes.
module tb_jay_core;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       sc;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef JAY_CYCLE_COUNT_EN
  logic [31:0] cycle_cnt;
`endif

  logic [8:0] rom [256];
  logic [7:0] dmem [256];
  wr_t  exp_q [$];
  vec_t vecs [10];

  int n_checks = 0;
  int n_fail = 0;
  int re_cnt = 0;
  logic both_seen = 1'b0;
  logic end_fetch = 1'b0;

  jay_if #(.W(8), .D(12)) bus ();

  jay_core #(.W(8), .D(12), .START_PC(0), .END_PC(128)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef JAY_CYCLE_COUNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction ROM: word appears the cycle after imem_rd, held otherwise
  always @(posedge clk) begin
    if (bus.imem_rd) bus.imem_data <= rom[bus.imem_addr[7:0]];
  end

  // Synchronous data memory
  always @(posedge clk) begin
    if (bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
    if (bus.dmem_re) bus.dmem_rdata <= dmem[bus.dmem_addr];
  end

  function automatic logic [8:0] ins(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb);
    return {op, ra, rb};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_rom(input logic [8:0] fill);
    for (int i = 0; i < 256; i++) rom[i] = fill;
  endtask

  // Pulse start, then sample each cycle until done; lat = cycles from start edge to done
  task automatic run_prog(input int budget, input int mid, output int lat, output int bc);
    lat = -1;
    bc = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < budget; j++) begin
      @(negedge clk);
      bus.start = (j == mid) ? 1'b1 : 1'b0;
      if (bus.done) begin
        lat = j;
        break;
      end
      if (bus.busy) bc++;
    end
    bus.start = 1'b0;
    if (lat < 0) $display("FAIL run_timeout: no done within %0d cycles", budget);
  endtask

  // Write monitor: each observed store is compared against the scoreboard head
  initial begin : mon
    wr_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.dmem_we) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: addr=%0h data=%0h, expected no write", bus.dmem_addr, bus.dmem_wdata);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(bus.dmem_addr), 32'(e.addr));
            chk("wr_data", 32'(bus.dmem_wdata), 32'(e.data));
          end
        end
        if (bus.dmem_re) re_cnt++;
        if (bus.dmem_re && bus.dmem_we) both_seen = 1'b1;
        if (bus.imem_rd && (bus.imem_addr == 12'd128)) end_fetch = 1'b1;
      end
    end
  end

  initial begin : main
    int lat;
    int bc;
    vecs[0] = '{3'd0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    vecs[1] = '{3'd0, 8'hF0, 8'h10, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{3'd0, 8'hFF, 8'h02, 8'h01, 1'b0, 1'b1};
    vecs[3] = '{3'd1, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{3'd1, 8'h3C, 8'h3C, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{3'd2, 8'h81, 8'h00, 8'h02, 1'b0, 1'b1};
    vecs[6] = '{3'd2, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{3'd3, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[8] = '{3'd3, 8'h10, 8'h07, 8'h17, 1'b0, 1'b0};
    vecs[9] = '{3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};

    bus.start = 1'b0;
    bus.imem_data = 9'd0;
    bus.dmem_rdata = 8'd0;
    for (int i = 0; i < 256; i++) dmem[i] = 8'd0;
    clear_rom(9'h1C0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_imem_rd", 32'(bus.imem_rd), 32'd0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
    chk("rst_dmem_re", 32'(bus.dmem_re), 32'd0);
    chk("rst_dmem_addr", 32'(bus.dmem_addr), 32'd0);
    chk("rst_dmem_wdata", 32'(bus.dmem_wdata), 32'd0);
`ifdef JAY_CYCLE_COUNT_EN
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
`endif
    reset = 1'b0;

    // ADDI R1,7 ; ADDI R1,7 ; ST R1->[R0] ; HALT  => mem[0]=14, done 8 cycles after start
    rom[0] = ins(3'd3, 3'd1, 3'd7);
    rom[1] = ins(3'd3, 3'd1, 3'd7);
    rom[2] = ins(3'd5, 3'd1, 3'd0);
    rom[3] = ins(3'd7, 3'd0, 3'd0);
    exp_q.push_back(wr_t'{8'h00, 8'd14});
    run_prog(50, -1, lat, bc);
    chk("halt_latency", 32'(lat), 32'd8);
    chk("halt_busy_cycles", 32'(bc), 32'd8);
    chk("halt_busy_low", 32'(bus.busy), 32'd0);
    chk("halt_done_high", 32'(bus.done), 32'd1);
    chk("halt_mem0", 32'(dmem[0]), 32'd14);
    @(negedge clk);
    chk("halt_busy_stays_low", 32'(bus.busy), 32'd0);
    chk("halt_done_held", 32'(bus.done), 32'd1);

    // Reset asserted in the middle of a store's EXEC cycle
    clear_rom(9'h1C0);
    rom[0] = ins(3'd5, 3'd1, 3'd0);
    exp_q.push_back(wr_t'{8'h00, 8'd14});
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("st_we_before_reset", 32'(bus.dmem_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_dmem_we", 32'(bus.dmem_we), 32'd0);
    chk("rstmid_dmem_re", 32'(bus.dmem_re), 32'd0);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_done", 32'(bus.done), 32'd0);
    chk("rstmid_pc", 32'(bus.imem_addr), 32'd0);
    chk("rstmid_imem_rd", 32'(bus.imem_rd), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_qempty", 32'(exp_q.size()), 32'd0);

    // Setup: R5=1, R6=2, R4=10 (registers persist across runs)
    clear_rom(9'h1C0);
    rom[0] = ins(3'd3, 3'd5, 3'd1);
    rom[1] = ins(3'd3, 3'd6, 3'd2);
    rom[2] = ins(3'd3, 3'd4, 3'd5);
    rom[3] = ins(3'd3, 3'd4, 3'd5);
    run_prog(50, -1, lat, bc);
    chk("setup_latency", 32'(lat), 32'd10);

    // ALU vectors: result -> mem[0], sc -> mem[2], z (via BNZ path) -> mem[1]
    for (int i = 0; i < 10; i++) begin
      clear_rom(9'h1C0);
      rom[0]  = ins(3'd1, 3'd3, 3'd3);
      rom[1]  = ins(3'd4, 3'd1, 3'd5);
      rom[2]  = ins(3'd4, 3'd2, 3'd6);
      rom[3]  = (vecs[i].op == 3'd3) ? ins(3'd3, 3'd1, vecs[i].b[2:0]) : ins(vecs[i].op, 3'd1, 3'd2);
      rom[4]  = ins(3'd5, 3'd1, 3'd0);
      rom[5]  = ins(3'd6, 3'd0, 3'd4);
      rom[6]  = ins(3'd2, 3'd3, 3'd0);
      rom[7]  = ins(3'd5, 3'd3, 3'd6);
      rom[8]  = ins(3'd5, 3'd5, 3'd5);
      rom[10] = ins(3'd2, 3'd3, 3'd0);
      rom[11] = ins(3'd5, 3'd3, 3'd6);
      rom[12] = ins(3'd5, 3'd0, 3'd5);
      dmem[1] = vecs[i].a;
      dmem[2] = vecs[i].b;
      exp_q.push_back(wr_t'{8'h00, vecs[i].res});
      exp_q.push_back(wr_t'{8'h02, {7'd0, vecs[i].sc}});
      exp_q.push_back(wr_t'{8'h01, {7'd0, vecs[i].z}});
      run_prog(200, -1, lat, bc);
      chk($sformatf("vec%0d_done", i), 32'(bus.done), 32'd1);
      chk($sformatf("vec%0d_qempty", i), 32'(exp_q.size()), 32'd0);
    end

    // Countdown loop: R2=3, body stores R2 then adds R7=0xFF, BNZ back while nonzero
    clear_rom(9'h1C0);
    rom[0]  = ins(3'd1, 3'd2, 3'd2);
    rom[1]  = ins(3'd3, 3'd2, 3'd3);
    rom[2]  = ins(3'd4, 3'd7, 3'd6);
    rom[3]  = ins(3'd6, 3'd0, 3'd4);
    rom[10] = ins(3'd5, 3'd2, 3'd5);
    rom[11] = ins(3'd0, 3'd2, 3'd7);
    rom[12] = ins(3'd6, 3'd0, 3'd4);
    dmem[2] = 8'hFF;
    exp_q.push_back(wr_t'{8'h01, 8'd3});
    exp_q.push_back(wr_t'{8'h01, 8'd2});
    exp_q.push_back(wr_t'{8'h01, 8'd1});
    run_prog(200, -1, lat, bc);
    chk("loop_latency", 32'(lat), 32'd29);
    chk("loop_qempty", 32'(exp_q.size()), 32'd0);
    chk("loop_halt_pc", 32'(bus.imem_addr), 32'd13);

    // LD R3,[R2] (R2=0, mem[0]=0x5A), ST R3->[R5], HALT; start pulsed mid-run
    clear_rom(9'h1C0);
    rom[0] = ins(3'd4, 3'd3, 3'd2);
    rom[1] = ins(3'd5, 3'd3, 3'd5);
    dmem[0] = 8'h5A;
    re_cnt = 0;
    exp_q.push_back(wr_t'{8'h01, 8'h5A});
    run_prog(50, 3, lat, bc);
    chk("ld_latency", 32'(lat), 32'd7);
    chk("ld_re_pulses", 32'(re_cnt), 32'd1);
    chk("ld_qempty", 32'(exp_q.size()), 32'd0);
    chk("ld_mem1", 32'(dmem[1]), 32'h5A);

    // No HALT: run ends when pc reaches END_PC without fetching it
    clear_rom(ins(3'd1, 3'd0, 3'd0));
    end_fetch = 1'b0;
    run_prog(400, -1, lat, bc);
    chk("end_latency", 32'(lat), 32'd257);
    chk("end_busy_cycles", 32'(bc), 32'd257);
    chk("end_pc", 32'(bus.imem_addr), 32'd128);
    chk("end_no_fetch", 32'(end_fetch), 32'd0);
`ifdef JAY_CYCLE_COUNT_EN
    chk("end_cycle_cnt", cycle_cnt, 32'd257);
    repeat (3) @(negedge clk);
    chk("end_cycle_cnt_hold", cycle_cnt, 32'd257);
`endif
    chk("re_we_exclusive", 32'(both_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
